multi_tap_accumulator: RTL and testbench
========================================

Name: multi_tap_accumulator

Overview:
Parametrised accumulate-and-dump engine for one tracking channel arm (I or Q), integrating carrier-mixed samples against NUM_TAPS code replicas (early/prompt/late by default) in parallel. Adds sample qualification, per-dump sample counting, and a read-acknowledge handshake with missed-dump detection. Sits between the carrier mixer/code generator and the tracking register bank; one instance per arm.

Parameters:
NUM_TAPS, 3, number of code taps integrated in parallel (tap 0 = early, 1 = prompt, 2 = late).
ACC_W, 16, signed accumulator/result width per tap (>= MAG_W+2).
MAG_W, 3, carrier-mix magnitude width (unsigned).
CNT_W, 16, sample-count width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
code  in  NUM_TAPS  code chip per tap; 0 = -1, 1 = +1
carrier_mix_sign  in  1  0 = negative, 1 = positive
carrier_mix_mag  in  MAG_W  unsigned carrier-mix magnitude
sample_valid  in  1  current sample qualifies for integration
dump_enable  in  1  end-of-integration strobe
rd_ack  in  1  software/bus has read the latched results
accumulation  out  NUM_TAPS*ACC_W  latched signed results; tap t at [t*ACC_W +: ACC_W]
dump_count  out  CNT_W  number of samples in the latched integration
dump_valid  out  1  one-cycle pulse when accumulation updates
new_data  out  1  latched results not yet acknowledged
missed_dump  out  1  sticky: dump overwrote unacknowledged results
overflow  out  NUM_TAPS  sticky per-tap saturation flag (macro-dependent)

Behaviour:
- Reset (rst=1 at posedge clk): accumulation, internal accumulators, sample counter, dump_count, dump_valid, new_data, missed_dump, overflow all 0. Reset mid-integration discards partial sums.
- Per tap t, contribution c_t = +mag if code[t]==carrier_mix_sign else -mag; mag zero-extended to ACC_W+1 bits before add. c_t = 0 when sample_valid=0.
- No dump: acc_t <= acc_t + c_t; count <= count + sample_valid, count saturates at 2^CNT_W-1.
- dump_enable=1: accumulation[t] <= acc_t (pre-add value), dump_count <= count; restart acc_t <= c_t, count <= sample_valid (current sample starts next integration). Latency: results visible the cycle after the dump strobe, coincident with dump_valid=1.
- Consecutive dump strobes legal: second latches single-sample (or zero) sum.
- new_data: set on dump; cleared on rd_ack. Dump and rd_ack in same cycle: new_data=1 (dump wins), missed_dump unchanged.
- missed_dump: set when dump occurs while new_data=1 and rd_ack=0; cleared only by rst or rd_ack with no simultaneous dump.
- overflow: cleared on rd_ack (same priority as new_data); set per macro rules below; a dump does not clear it.
- rd_ack with new_data=0: no effect except clearing sticky flags.
- No state machine beyond new_data/missed_dump flag logic; fully pipelined, one sample per clock.

Optional Feature:
Macro ACCUM_SATURATE_EN.
- Defined: each add clamps to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]; any clamp sets overflow[t]; accumulator holds at the rail until dump.
- Undefined: two's-complement wrap (legacy behaviour); overflow tied to 0; clamp logic absent.

Decomposition:
- Package accum_pkg: tap index constants (TAP_EARLY=0, TAP_PROMPT=1, TAP_LATE=2), function computing signed contribution from code/sign/mag, saturating-add function parametrised on width.
- One sub-module: accum_tap (single-tap accumulator with saturation/overflow), generated NUM_TAPS times; flag and counter logic stays in top.

Test Plan:
- Reset then 10 valid samples mag=3, sign=1, code=3'b111, dump -> accumulation all taps = 30, dump_count=10, dump_valid 1 cycle, new_data=1.
- code=3'b101, sign=1, mag=6, 4 valid samples interleaved with 3 sample_valid=0 cycles, dump -> taps 0,2 = 24, tap 1 = -24, dump_count=4.
- Dump strobe on same cycle as sample mag=2 (match), then 5 more matched mag=2, dump -> second result = 12, dump_count=6.
- Two dumps without rd_ack -> missed_dump=1; rd_ack -> new_data=0, missed_dump=0; dump+rd_ack same cycle -> new_data=1, missed_dump=0.
- ACC_W=8, ACCUM_SATURATE_EN defined, 50 samples mag=6 matched -> accumulation=127, overflow=3'b111; undefined -> 300 mod 256 = 44, overflow=0.
- Assert rst mid-integration after 7 samples, release, 2 samples mag=1 matched, dump -> accumulation=2, dump_count=2, all flags cleared before.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared definitions for multi_tap_accumulator: tap indices, per-tap contribution
// and width-parametrised saturating add used when ACCUM_SATURATE_EN is defined.
package accum_pkg;

  typedef enum int unsigned {
    TAP_EARLY  = 0,
    TAP_PROMPT = 1,
    TAP_LATE   = 2
  } tap_idx_e;

  // Arithmetic is carried at a fixed wide width and narrowed by the caller,
  // so one function body serves every ACC_W.
  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic wide_t tap_contrib(input logic        code_bit,
                                        input logic        mix_sign,
                                        input logic [31:0] mag,
                                        input logic        valid);
    wide_t m;
    m = wide_t'({32'd0, mag});
    if (!valid) return '0;
    return (code_bit == mix_sign) ? m : -m;
  endfunction

  function automatic wide_t rail_hi(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t rail_lo(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    wide_t s;
    s = a + b;
    if (s > rail_hi(w)) return rail_hi(w);
    if (s < rail_lo(w)) return rail_lo(w);
    return s;
  endfunction

  function automatic logic sat_clips(input wide_t a, input wide_t b, input int w);
    wide_t s;
    s = a + b;
    return (s > rail_hi(w)) || (s < rail_lo(w));
  endfunction

endpackage

// File: rtl/accum_tap.sv
// Single-tap integrate-and-dump accumulator with latched result.
// ACCUM_SATURATE_EN selects clamping with a sticky overflow flag; otherwise wraps.
module accum_tap
  import accum_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int MAG_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef ACCUM_SATURATE_EN
  input  logic                    rd_ack,
  output logic                    overflow,
`endif
  input  logic                    code_bit,
  input  logic                    mix_sign,
  input  logic [MAG_W-1:0]        mag,
  input  logic                    sample_valid,
  input  logic                    dump,
  output logic signed [ACC_W-1:0] result
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] result_q, result_d;
  wide_t                   base;
  wide_t                   contrib;

`ifdef ACCUM_SATURATE_EN
  logic overflow_q, overflow_d;
  logic clip;
`endif

  always_comb begin
    // A dump restarts the integration from the current sample alone.
    base     = dump ? '0 : wide_t'(acc_q);
    contrib  = tap_contrib(code_bit, mix_sign, 32'(mag), sample_valid);
    result_d = dump ? acc_q : result_q;
`ifdef ACCUM_SATURATE_EN
    acc_d      = ACC_W'(sat_add(base, contrib, ACC_W));
    clip       = sat_clips(base, contrib, ACC_W);
    overflow_d = clip | (overflow_q & ~(rd_ack & ~dump));
`else
    acc_d      = ACC_W'(base + contrib);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      result_q   <= '0;
`ifdef ACCUM_SATURATE_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      acc_q      <= acc_d;
      result_q   <= result_d;
`ifdef ACCUM_SATURATE_EN
      overflow_q <= overflow_d;
`endif
    end
  end

  assign result = result_q;
`ifdef ACCUM_SATURATE_EN
  assign overflow = overflow_q;
`endif

endmodule

// File: rtl/multi_tap_accumulator.sv
// Accumulate-and-dump engine for one tracking arm: NUM_TAPS parallel code taps,
// sample counting and read-acknowledge flags. ACCUM_SATURATE_EN enables clamping.
module multi_tap_accumulator
  import accum_pkg::*;
#(
  parameter int NUM_TAPS = 3,
  parameter int ACC_W    = 16,
  parameter int MAG_W    = 3,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_TAPS-1:0]       code,
  input  logic                      carrier_mix_sign,
  input  logic [MAG_W-1:0]          carrier_mix_mag,
  input  logic                      sample_valid,
  input  logic                      dump_enable,
  input  logic                      rd_ack,
  output logic [NUM_TAPS*ACC_W-1:0] accumulation,
  output logic [CNT_W-1:0]          dump_count,
  output logic                      dump_valid,
  output logic                      new_data,
  output logic                      missed_dump,
  output logic [NUM_TAPS-1:0]       overflow
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dump_count_q, dump_count_d;
  logic             dump_valid_q, dump_valid_d;
  logic             new_data_q, new_data_d;
  logic             missed_dump_q, missed_dump_d;

  for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
    accum_tap #(
      .ACC_W(ACC_W),
      .MAG_W(MAG_W)
    ) u_tap (
      .clk         (clk),
      .rst         (rst),
`ifdef ACCUM_SATURATE_EN
      .rd_ack      (rd_ack),
      .overflow    (overflow[t]),
`endif
      .code_bit    (code[t]),
      .mix_sign    (carrier_mix_sign),
      .mag         (carrier_mix_mag),
      .sample_valid(sample_valid),
      .dump        (dump_enable),
      .result      (accumulation[t*ACC_W +: ACC_W])
    );
  end

`ifndef ACCUM_SATURATE_EN
  assign overflow = '0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (dump_enable)
      cnt_d = CNT_W'(sample_valid);
    else if (sample_valid && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);

    dump_count_d = dump_enable ? cnt_q : dump_count_q;
    dump_valid_d = dump_enable;

    // A dump coinciding with rd_ack counts as fresh data, not as a miss.
    new_data_d    = dump_enable | (new_data_q & ~rd_ack);
    missed_dump_d = missed_dump_q;
    if (dump_enable && new_data_q && !rd_ack)
      missed_dump_d = 1'b1;
    else if (rd_ack && !dump_enable)
      missed_dump_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      dump_count_q  <= '0;
      dump_valid_q  <= 1'b0;
      new_data_q    <= 1'b0;
      missed_dump_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dump_count_q  <= dump_count_d;
      dump_valid_q  <= dump_valid_d;
      new_data_q    <= new_data_d;
      missed_dump_q <= missed_dump_d;
    end
  end

  assign dump_count  = dump_count_q;
  assign dump_valid  = dump_valid_q;
  assign new_data    = new_data_q;
  assign missed_dump = missed_dump_q;

endmodule

// File: tb/tb_multi_tap_accumulator.sv
// Scoreboard bench for multi_tap_accumulator; reference model follows
// ACCUM_SATURATE_EN when that macro is defined for the build.
module tb_multi_tap_accumulator;

  localparam int NT = 3;
  localparam int AW = 8;
  localparam int MW = 3;
  localparam int CW = 6;
  localparam int HI = 2 ** (AW - 1) - 1;
  localparam int LO = -(2 ** (AW - 1));
  localparam int MOD = 2 ** AW;
  localparam int CMAX = 2 ** CW - 1;
`ifdef ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NT-1:0]    code;
  logic             carrier_mix_sign;
  logic [MW-1:0]    carrier_mix_mag;
  logic             sample_valid;
  logic             dump_enable;
  logic             rd_ack;
  logic [NT*AW-1:0] accumulation;
  logic [CW-1:0]    dump_count;
  logic             dump_valid;
  logic             new_data;
  logic             missed_dump;
  logic [NT-1:0]    overflow;

  always #5 clk = ~clk;

  multi_tap_accumulator #(
    .NUM_TAPS(NT),
    .ACC_W   (AW),
    .MAG_W   (MW),
    .CNT_W   (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .code            (code),
    .carrier_mix_sign(carrier_mix_sign),
    .carrier_mix_mag (carrier_mix_mag),
    .sample_valid    (sample_valid),
    .dump_enable     (dump_enable),
    .rd_ack          (rd_ack),
    .accumulation    (accumulation),
    .dump_count      (dump_count),
    .dump_valid      (dump_valid),
    .new_data        (new_data),
    .missed_dump     (missed_dump),
    .overflow        (overflow)
  );

  typedef struct {
    logic [NT*AW-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [2:0]       flags;
    logic [NT-1:0]    ovf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: integers with explicit wrap/clamp after each add.
  int m_acc[NT];
  int m_res[NT];
  int m_cnt, m_dcnt;
  bit m_dv, m_nd, m_md;
  bit m_ovf[NT];

  function automatic int fold(input int x, output bit clip);
    int r;
    clip = 1'b0;
    if (SAT) begin
      if (x > HI) begin clip = 1'b1; return HI; end
      if (x < LO) begin clip = 1'b1; return LO; end
      return x;
    end
    r = (x - LO) % MOD;
    if (r < 0) r += MOD;
    return r + LO;
  endfunction

  task automatic step(input bit r, input logic [NT-1:0] c, input bit s, input int mg,
                      input bit v, input bit d, input bit a);
    exp_t        e;
    bit          clip;
    int          sum;
    int          ct;
    logic [31:0] tmp;
    @(negedge clk);
    rst = r; code = c; carrier_mix_sign = s; carrier_mix_mag = MW'(mg);
    sample_valid = v; dump_enable = d; rd_ack = a;
    if (r) begin
      for (int t = 0; t < NT; t++) begin
        m_acc[t] = 0; m_res[t] = 0; m_ovf[t] = 1'b0;
      end
      m_cnt = 0; m_dcnt = 0; m_dv = 1'b0; m_nd = 1'b0; m_md = 1'b0;
    end else begin
      for (int t = 0; t < NT; t++) begin
        ct = !v ? 0 : ((c[t] == s) ? mg : -mg);
        if (d) begin
          m_res[t] = m_acc[t];
          sum = ct;
        end else begin
          sum = m_acc[t] + ct;
        end
        m_acc[t] = fold(sum, clip);
        m_ovf[t] = clip || (m_ovf[t] && !(a && !d));
      end
      if (d) begin
        m_dcnt = m_cnt;
        m_cnt  = v ? 1 : 0;
      end else if (v && m_cnt < CMAX) begin
        m_cnt++;
      end
      if (d && m_nd && !a) m_md = 1'b1;
      else if (a && !d)    m_md = 1'b0;
      m_nd = d || (m_nd && !a);
      m_dv = d;
    end
    for (int t = 0; t < NT; t++) begin
      tmp = m_res[t];
      e.acc[t*AW +: AW] = tmp[AW-1:0];
      e.ovf[t] = m_ovf[t];
    end
    tmp     = m_dcnt;
    e.cnt   = tmp[CW-1:0];
    e.flags = {m_dv, m_nd, m_md};
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per clock, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({dump_valid, new_data, missed_dump} !== e.flags) begin
          fails++;
          $display("FAIL flags t=%0t got dv/nd/md=%b want %b", $time,
                   {dump_valid, new_data, missed_dump}, e.flags);
        end
        tests++;
        if (overflow !== e.ovf) begin
          fails++;
          $display("FAIL overflow t=%0t got %b want %b", $time, overflow, e.ovf);
        end
        tests++;
        if (accumulation !== e.acc) begin
          fails++;
          $display("FAIL accumulation t=%0t got %h want %h", $time, accumulation, e.acc);
        end
        tests++;
        if (dump_count !== e.cnt) begin
          fails++;
          $display("FAIL dump_count t=%0t got %0d want %0d", $time, dump_count, e.cnt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          s, r, v, d, a;
    logic [NT-1:0] c;
    rst = 1'b1; code = '0; carrier_mix_sign = 1'b0; carrier_mix_mag = '0;
    sample_valid = 1'b0; dump_enable = 1'b0; rd_ack = 1'b0;

    repeat (2) step(1, 3'b000, 0, 0, 0, 0, 0);
    // 10 matched samples of 3 -> 30 on every tap
    repeat (10) step(0, 3'b111, 1, 3, 1, 0, 0);
    step(0, 3'b000, 0, 0, 0, 1, 0);
    step(0, 3'b000, 0, 0, 0, 0, 1);
    // qualified samples interleaved with idle ones
    for (int i = 0; i < 7; i++) step(0, 3'b101, 1, 6, (i % 2) == 0, 0, 0);
    step(0, 3'b000, 0, 0, 0, 1, 0);
    step(0, 3'b000, 0, 0, 0, 0, 1);
    // dump carrying a sample, then a second dump without ack
    step(0, 3'b111, 1, 2, 1, 1, 0);
    repeat (5) step(0, 3'b111, 1, 2, 1, 0, 0);
    step(0, 3'b000, 0, 0, 0, 1, 0);
    step(0, 3'b000, 0, 0, 0, 0, 1);
    step(0, 3'b000, 0, 0, 0, 1, 1);
    step(0, 3'b000, 0, 0, 0, 1, 1);
    step(0, 3'b000, 0, 0, 0, 0, 1);
    // long run past the accumulator range
    repeat (50) step(0, 3'b111, 1, 6, 1, 0, 0);
    step(0, 3'b000, 0, 0, 0, 1, 0);
    step(0, 3'b000, 0, 0, 0, 0, 0);
    step(0, 3'b000, 0, 0, 0, 0, 1);
    // reset mid-integration
    repeat (7) step(0, 3'b011, 1, 5, 1, 0, 0);
    step(1, 3'b000, 0, 0, 0, 0, 0);
    repeat (2) step(0, 3'b000, 0, 1, 1, 0, 0);
    step(0, 3'b000, 0, 0, 0, 1, 0);
    step(0, 3'b000, 0, 0, 0, 0, 1);
    // sample counter saturation
    repeat (70) step(0, 3'b010, 0, 1, 1, 0, 0);
    step(0, 3'b000, 0, 0, 0, 1, 0);
    step(0, 3'b000, 0, 0, 0, 0, 1);

    // unbiased random traffic
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 11) == 0);
      a = ($urandom_range(0, 5) == 0);
      s = 1'($urandom_range(0, 1));
      c = NT'($urandom);
      step(r, c, s, int'($urandom_range(0, 7)), v, d, a);
    end
    // biased toward matched code so sums reach the rails
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 999) == 0);
      v = ($urandom_range(0, 7) != 0);
      d = ($urandom_range(0, 39) == 0);
      a = ($urandom_range(0, 9) == 0);
      s = 1'($urandom_range(0, 1));
      for (int t = 0; t < NT; t++) c[t] = ($urandom_range(0, 7) == 0) ? ~s : s;
      step(r, c, s, int'($urandom_range(4, 7)), v, d, a);
    end

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
